// File: rtl/field_packer.sv
// field_packer: streaming packer of variable-width fields into WORD_W-bit words.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   field handshake; in_ready never depends on in_valid
//   in_data [FIELD_W]   field bits, right-aligned; bits at or above in_len are ignored
//   in_len  [LEN_W]     field width, 0 = no data, values above FIELD_W clamp to FIELD_W
//   in_last             flush the partial word after this field
//   out_valid/out_ready word handshake; out_data/out_count held while stalled
//   out_data [WORD_W]   packed word, unused bits zero
//   out_count [CNT_W]   number of valid bits in out_data (1..WORD_W)
//
// Build option: define FIELD_PACKER_MSB_FIRST_EN to pack MSB-first (first field in
// the top bits, partial words left-aligned). Default is LSB-first.
module field_packer #(
    parameter int WORD_W = 32,
    parameter int FIELD_W = 8,
    localparam int LEN_W = $clog2(FIELD_W) + 1,
    localparam int CNT_W = $clog2(WORD_W) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_data,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [CNT_W-1:0]   out_count
);
    localparam int FILL_W = $clog2(WORD_W);
    localparam int WIDE_W = WORD_W + FIELD_W;

    typedef enum logic {RUN, FLUSH2} state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   acc, acc_nxt;
    logic [FILL_W-1:0]   fill, fill_nxt;
    logic [LEN_W-1:0]    len;
    logic [FIELD_W-1:0]  field;
    logic [FILL_W:0]     sum;
    logic [WIDE_W-1:0]   wide;
    logic [WORD_W-1:0]   word, rest;
    logic                full, free, accept, load;
    logic [WORD_W-1:0]   load_data;
    logic [CNT_W-1:0]    load_count;

    assign len    = (in_len > LEN_W'(FIELD_W)) ? LEN_W'(FIELD_W) : in_len;
    assign field  = in_data & ~({FIELD_W{1'b1}} << len);
    // fill < WORD_W and len <= FIELD_W <= WORD_W/2, so the carry bit alone flags a full word
    assign sum    = {1'b0, fill} + (FILL_W + 1)'(len);
    assign full   = sum[FILL_W];
    assign free   = !out_valid || out_ready;
    assign in_ready = (state == RUN) && free;
    assign accept = in_valid && in_ready;

    // wide holds the accumulator plus room for the overflow of one straddling field;
    // word is the (possibly completed) word, rest the carry into the next word.
`ifdef FIELD_PACKER_MSB_FIRST_EN
    logic [FIELD_W-1:0] field_left;
    assign field_left = field << (LEN_W'(FIELD_W) - len);
    assign wide = {acc, {FIELD_W{1'b0}}} | ({field_left, {WORD_W{1'b0}}} >> fill);
    assign word = wide[WIDE_W-1 -: WORD_W];
    assign rest = {wide[FIELD_W-1:0], {(WORD_W - FIELD_W){1'b0}}};
`else
    assign wide = {{FIELD_W{1'b0}}, acc} | (WIDE_W'(field) << fill);
    assign word = wide[WORD_W-1:0];
    assign rest = WORD_W'(wide[WIDE_W-1:WORD_W]);
`endif

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        fill_nxt   = fill;
        load       = 1'b0;
        load_data  = word;
        load_count = CNT_W'(WORD_W);
        if (state == FLUSH2) begin
            if (free) begin
                load       = 1'b1;
                load_data  = acc;
                load_count = {1'b0, fill};
                acc_nxt    = '0;
                fill_nxt   = '0;
                state_nxt  = RUN;
            end
        end else if (accept) begin
            fill_nxt = sum[FILL_W-1:0];
            acc_nxt  = full ? rest : word;
            if (full) begin
                load = 1'b1;
                // a leftover carry after a last field needs its own word
                if (in_last && sum[FILL_W-1:0] != '0)
                    state_nxt = FLUSH2;
            end else if (in_last && sum[FILL_W-1:0] != '0) begin
                load       = 1'b1;
                load_count = {1'b0, sum[FILL_W-1:0]};
                acc_nxt    = '0;
                fill_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            acc       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            fill  <= fill_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_count <= load_count;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed self-checking bench for field_packer (LSB-first build).
module tb_field_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [3:0]  in_len = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_count;
    int          n_checks = 0;
    int          n_fail = 0;

    field_packer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one field, wait (bounded) for in_ready, then let it be accepted
    task automatic push(input logic [7:0] d, input logic [3:0] l, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_last  = last;
        for (int i = 0; i < 50 && !in_ready; i++) step();
        chk("in_ready_wait", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [5:0] c);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, out_count, c);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_out_count"}, out_count, 6'd0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        step();
        chk_reset("post_release");

        // four bytes, last on the exact word boundary: one word and nothing after it
        push(8'h11, 4'd8, 1'b0);
        push(8'h22, 4'd8, 1'b0);
        push(8'h33, 4'd8, 1'b0);
        chk("no_word_yet", out_valid, 1'b0);
        push(8'h44, 4'd8, 1'b1);
        chk_word("four_bytes", 32'h44332211, 6'd32);
        step();
        chk("no_empty_word", out_valid, 1'b0);

        // straddling field, then a zero-length last flushes the carry
        for (int i = 1; i <= 7; i++) push(8'(i), 4'd4, 1'b0);
        push(8'hAB, 4'd8, 1'b0);
        chk_word("straddle", 32'hB7654321, 6'd32);
        push(8'h00, 4'd0, 1'b1);
        chk_word("flush_len0", 32'h0000000A, 6'd4);

        // last on the straddling field goes through FLUSH2
        for (int i = 1; i <= 7; i++) push(8'(i), 4'd4, 1'b0);
        push(8'hAB, 4'd8, 1'b1);
        chk_word("flush2_full", 32'hB7654321, 6'd32);
        chk("flush2_in_ready", in_ready, 1'b0);
        step();
        chk_word("flush2_carry", 32'h0000000A, 6'd4);
        chk("flush2_back_run", in_ready, 1'b1);

        // length clamp and masking of bits above len
        push(8'hFF, 4'd15, 1'b1);
        chk_word("clamp", 32'h000000FF, 6'd8);
        push(8'hFF, 4'd3, 1'b1);
        chk_word("mask", 32'h00000007, 6'd3);

        // back-pressure: word held, in_ready low, release frees input same cycle
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_word("stall_hold", 32'h00000007, 6'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        step();
        chk("release_consumed", out_valid, 1'b0);

        // reset with fill = 12
        push(8'h11, 4'd8, 1'b0);
        push(8'h02, 4'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_fill12");
        step();
        rst_n = 1'b1;
        step();

        // reset while in FLUSH2 with the full word stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(8'(i), 4'd4, 1'b0);
        push(8'hAB, 4'd8, 1'b1);
        chk_word("pre_rst_full", 32'hB7654321, 6'd32);
        chk("pre_rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_flush2");
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("no_stale_flush", out_valid, 1'b0);
        push(8'h11, 4'd8, 1'b1);
        chk_word("fresh", 32'h00000011, 6'd8);
        step();
        chk("fresh_drained", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
